regfile_scoreboard: RTL and testbench
=====================================

Name: regfile_scoreboard

Overview:
- Parametrised general-purpose register file: two asynchronous read ports, one synchronous write port, and an integrated per-register pending-write scoreboard.
- Replaces the fixed 8x32 register/mux tree in registers_handler.
- Sits between decode (read and issue), writeback (write) and hazard control (busy flags).
- Register 0 is hardwired to zero, per RISC-V.

Parameters:
- XLEN, 32, data width of each register.
- NUM_REGS, 32, number of architectural registers (power of 2, ≥2).
- AW (localparam), $clog2(NUM_REGS), register address width.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- rs1_addr  in  AW  read port 1 address
- rs2_addr  in  AW  read port 2 address
- rs1_data  out  XLEN  read port 1 data
- rs2_data  out  XLEN  read port 2 data
- rd_we  in  1  writeback enable
- rd_addr  in  AW  writeback destination
- rd_data  in  XLEN  writeback data
- issue_valid  in  1  instruction issued that will write issue_rd
- issue_rd  in  AW  destination of issued instruction
- rs1_busy  out  1  rs1_addr has a pending write
- rs2_busy  out  1  rs2_addr has a pending write

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, rst.
- Reset: on a clk edge with rst=1, all registers clear to 0 and all busy bits clear to 0. Write and issue are ignored in that cycle. Next cycle rs*_data=0 and rs*_busy=0.
- Read: combinational, zero latency; rsN_data = regs[rsN_addr]. Address 0 always reads 0.
- Write: at the edge with rd_we=1 and rd_addr≠0, regs[rd_addr] <= rd_data. Writes to 0 are discarded with no side effects.
- Scoreboard, one busy bit per register (bit 0 constant 0):
  - Set at the edge when issue_valid=1 and issue_rd≠0.
  - Cleared at the edge when rd_we=1 and rd_addr≠0.
  - Same register issued and written back in the same cycle: set wins, because the new pending write supersedes the retiring one. The data write still occurs.
  - Writeback to a non-busy register is legal: data is written and busy stays 0.
  - Issue to an already-busy register is legal: busy stays 1 (no counting; in-order writeback).
- rsN_busy = busy[rsN_addr] (see Optional Feature); address 0 always reads 0.
- Mid-operation reset discards all pending-write tracking. Writebacks arriving after reset write data normally.
- All address inputs are full AW width; no out-of-range addresses exist.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - Write-to-read forwarding: if rd_we=1, rd_addr≠0 and rd_addr==rsN_addr, then rsN_data=rd_data in the same cycle.
  - rsN_busy is masked to 0 in that cycle unless issue_valid=1 and issue_rd==rsN_addr.
- Undefined:
  - Reads return only the stored value; new data is visible the cycle after the write edge.
  - rsN_busy reflects the registered bit only.

Decomposition:
- Shared package regfile_pkg holds:
  - default XLEN/NUM_REGS constants;
  - the ZERO_REG index constant (0);
  - a typedef for the register address width used by decode and writeback.
- One sub-module is natural: regfile_read_port (address → data/busy, including zero and bypass muxing), instantiated twice.
- Storage and scoreboard stay in the top.

Test Plan:
- Reset clears: pre-load regs[5]=0xDEADBEEF and busy[5]=1, assert rst one cycle → rs1_addr=5 gives rs1_data=0 and rs1_busy=0.
- Write/read and x0: write 0x12345678 to reg 7 and 0xFFFFFFFF to reg 0 → next cycle reg 7 reads 0x12345678 on both ports, reg 0 reads 0, and busy[0] never sets.
- Scoreboard lifecycle: issue rd=3 → rs2_busy=1 for addr 3 next cycle; writeback reg 3 with 0xA5 → busy=0 and data=0xA5 the following cycle.
- Simultaneous issue+writeback to reg 9 → data written, busy[9] remains 1; a second writeback clears it.
- Bypass with REGFILE_BYPASS_EN defined: rd_we=1, rd_addr=4, rd_data=0x55, rs1_addr=4 → rs1_data=0x55 and rs1_busy=0 in the same cycle. Without the macro, the old value is read that cycle.
- Parameter sweep NUM_REGS=8, XLEN=16: random writes checked against a reference model over 1000 cycles, with no address aliasing.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and types for the general-purpose register file and its
// pending-write scoreboard.
package regfile_pkg;

  localparam int unsigned DEFAULT_XLEN     = 32;
  localparam int unsigned DEFAULT_NUM_REGS = 32;
  localparam int unsigned DEFAULT_AW       = $clog2(DEFAULT_NUM_REGS);

  // Architectural x0: reads as zero, writes and issues to it are dropped.
  localparam int unsigned ZERO_REG = 0;

  typedef logic [DEFAULT_AW-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_scoreboard_read_port.sv
// One asynchronous read port: address -> data and pending-write flag, with x0
// forced to zero and optional write-to-read forwarding (REGFILE_BYPASS_EN).
module regfile_scoreboard_read_port
  import regfile_pkg::*;
#(
  parameter  int unsigned XLEN     = DEFAULT_XLEN,
  parameter  int unsigned NUM_REGS = DEFAULT_NUM_REGS,
  localparam int unsigned AW       = $clog2(NUM_REGS)
) (
  input  logic [XLEN-1:0]     regs [NUM_REGS],
  input  logic [NUM_REGS-1:0] busy,
  input  logic [AW-1:0]       rs_addr,
`ifdef REGFILE_BYPASS_EN
  input  logic                rd_we,
  input  logic [AW-1:0]       rd_addr,
  input  logic [XLEN-1:0]     rd_data,
  input  logic                issue_valid,
  input  logic [AW-1:0]       issue_rd,
`endif
  output logic [XLEN-1:0]     rs_data,
  output logic                rs_busy
);

  logic is_zero;

  assign is_zero = (rs_addr == AW'(ZERO_REG));

  always_comb begin
    rs_data = regs[rs_addr];
    rs_busy = busy[rs_addr];
`ifdef REGFILE_BYPASS_EN
    // The retiring value is visible now; only a same-cycle reissue keeps it busy.
    if (rd_we && (rd_addr != AW'(ZERO_REG)) && (rd_addr == rs_addr)) begin
      rs_data = rd_data;
      if (!(issue_valid && (issue_rd == rs_addr))) begin
        rs_busy = 1'b0;
      end
    end
`endif
    if (is_zero) begin
      rs_data = '0;
      rs_busy = 1'b0;
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Parametrised register file (2 async read, 1 sync write) with per-register
// pending-write scoreboard. Optional forwarding: define REGFILE_BYPASS_EN.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter  int unsigned XLEN     = DEFAULT_XLEN,
  parameter  int unsigned NUM_REGS = DEFAULT_NUM_REGS,
  localparam int unsigned AW       = $clog2(NUM_REGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic            rd_we,
  input  logic [AW-1:0]   rd_addr,
  input  logic [XLEN-1:0] rd_data,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  output logic            rs1_busy,
  output logic            rs2_busy
);

  logic [XLEN-1:0]     regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic                wb_fire;
  logic                issue_fire;

  assign wb_fire    = rd_we && (rd_addr != AW'(ZERO_REG));
  assign issue_fire = issue_valid && (issue_rd != AW'(ZERO_REG));

  // Clear before set so a same-cycle reissue of the retiring register stays busy.
  always_comb begin
    busy_d = busy_q;
    if (wb_fire) begin
      busy_d[rd_addr] = 1'b0;
    end
    if (issue_fire) begin
      busy_d[issue_rd] = 1'b1;
    end
    busy_d[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      if (wb_fire) begin
        regs_q[rd_addr] <= rd_data;
      end
      busy_q <= busy_d;
    end
  end

  regfile_scoreboard_read_port #(
    .XLEN     (XLEN),
    .NUM_REGS (NUM_REGS)
  ) u_rp1 (
    .regs        (regs_q),
    .busy        (busy_q),
    .rs_addr     (rs1_addr),
`ifdef REGFILE_BYPASS_EN
    .rd_we       (rd_we),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
`endif
    .rs_data     (rs1_data),
    .rs_busy     (rs1_busy)
  );

  regfile_scoreboard_read_port #(
    .XLEN     (XLEN),
    .NUM_REGS (NUM_REGS)
  ) u_rp2 (
    .regs        (regs_q),
    .busy        (busy_q),
    .rs_addr     (rs2_addr),
`ifdef REGFILE_BYPASS_EN
    .rd_we       (rd_we),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
`endif
    .rs_data     (rs2_data),
    .rs_busy     (rs2_busy)
  );

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench: 32x32 instance (directed + random) and 8x16 instance (random), both
// checked every cycle against a behavioural register/busy model.
module tb_regfile_scoreboard;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit check_en = 1'b0;

  // Instance A: default 32 registers x 32 bits
  logic        a_rst, a_rd_we, a_issue_valid;
  logic [4:0]  a_rs1_addr, a_rs2_addr, a_rd_addr, a_issue_rd;
  logic [31:0] a_rd_data, a_rs1_data, a_rs2_data;
  logic        a_rs1_busy, a_rs2_busy;

  // Instance B: 8 registers x 16 bits
  logic        b_rst, b_rd_we, b_issue_valid;
  logic [2:0]  b_rs1_addr, b_rs2_addr, b_rd_addr, b_issue_rd;
  logic [15:0] b_rd_data, b_rs1_data, b_rs2_data;
  logic        b_rs1_busy, b_rs2_busy;

  regfile_scoreboard dut_a (
    .clk(clk), .rst(a_rst),
    .rs1_addr(a_rs1_addr), .rs2_addr(a_rs2_addr),
    .rs1_data(a_rs1_data), .rs2_data(a_rs2_data),
    .rd_we(a_rd_we), .rd_addr(a_rd_addr), .rd_data(a_rd_data),
    .issue_valid(a_issue_valid), .issue_rd(a_issue_rd),
    .rs1_busy(a_rs1_busy), .rs2_busy(a_rs2_busy)
  );

  regfile_scoreboard #(.XLEN(16), .NUM_REGS(8)) dut_b (
    .clk(clk), .rst(b_rst),
    .rs1_addr(b_rs1_addr), .rs2_addr(b_rs2_addr),
    .rs1_data(b_rs1_data), .rs2_data(b_rs2_data),
    .rd_we(b_rd_we), .rd_addr(b_rd_addr), .rd_data(b_rd_data),
    .issue_valid(b_issue_valid), .issue_rd(b_issue_rd),
    .rs1_busy(b_rs1_busy), .rs2_busy(b_rs2_busy)
  );

  // Behavioural model: architectural values and "write outstanding" flags.
  logic [31:0] ma_reg  [32];
  bit          ma_busy [32];
  logic [15:0] mb_reg  [8];
  bit          mb_busy [8];

  always @(posedge clk) begin
    if (a_rst) begin
      for (int i = 0; i < 32; i++) begin ma_reg[i] = '0; ma_busy[i] = 0; end
    end else begin
      if (a_rd_we && a_rd_addr != 0) begin
        ma_reg[a_rd_addr]  = a_rd_data;
        ma_busy[a_rd_addr] = 0;
      end
      if (a_issue_valid && a_issue_rd != 0) ma_busy[a_issue_rd] = 1;
    end
    if (b_rst) begin
      for (int i = 0; i < 8; i++) begin mb_reg[i] = '0; mb_busy[i] = 0; end
    end else begin
      if (b_rd_we && b_rd_addr != 0) begin
        mb_reg[b_rd_addr]  = b_rd_data;
        mb_busy[b_rd_addr] = 0;
      end
      if (b_issue_valid && b_issue_rd != 0) mb_busy[b_issue_rd] = 1;
    end
  end

  function automatic logic [31:0] exp_a_data(int addr);
    if (addr == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (a_rd_we && a_rd_addr == addr) return a_rd_data;
`endif
    return ma_reg[addr];
  endfunction

  function automatic logic exp_a_busy(int addr);
    if (addr == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (a_rd_we && a_rd_addr == addr && !(a_issue_valid && a_issue_rd == addr)) return 1'b0;
`endif
    return ma_busy[addr];
  endfunction

  function automatic logic [15:0] exp_b_data(int addr);
    if (addr == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (b_rd_we && b_rd_addr == addr) return b_rd_data;
`endif
    return mb_reg[addr];
  endfunction

  function automatic logic exp_b_busy(int addr);
    if (addr == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (b_rd_we && b_rd_addr == addr && !(b_issue_valid && b_issue_rd == addr)) return 1'b0;
`endif
    return mb_busy[addr];
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      chk("a_rs1_data", a_rs1_data, exp_a_data(int'(a_rs1_addr)));
      chk("a_rs2_data", a_rs2_data, exp_a_data(int'(a_rs2_addr)));
      chk("a_rs1_busy", 32'(a_rs1_busy), 32'(exp_a_busy(int'(a_rs1_addr))));
      chk("a_rs2_busy", 32'(a_rs2_busy), 32'(exp_a_busy(int'(a_rs2_addr))));
      chk("b_rs1_data", 32'(b_rs1_data), 32'(exp_b_data(int'(b_rs1_addr))));
      chk("b_rs2_data", 32'(b_rs2_data), 32'(exp_b_data(int'(b_rs2_addr))));
      chk("b_rs1_busy", 32'(b_rs1_busy), 32'(exp_b_busy(int'(b_rs1_addr))));
      chk("b_rs2_busy", 32'(b_rs2_busy), 32'(exp_b_busy(int'(b_rs2_addr))));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_idle();
    a_rst = 0; a_rd_we = 0; a_rd_addr = '0; a_rd_data = '0;
    a_issue_valid = 0; a_issue_rd = '0;
  endtask

  initial begin
    a_idle();
    a_rst = 1; a_rs1_addr = '0; a_rs2_addr = '0;
    b_rst = 1; b_rd_we = 0; b_rd_addr = '0; b_rd_data = '0;
    b_issue_valid = 0; b_issue_rd = '0; b_rs1_addr = '0; b_rs2_addr = '0;
    step();
    check_en = 1'b1;
    step();
    a_rst = 0; b_rst = 0;

    // Reset state
    a_rs1_addr = 5'd5; a_rs2_addr = 5'd31;
    @(negedge clk);
    chk("reset_rs1_data", a_rs1_data, 32'h0);
    chk("reset_rs2_busy", 32'(a_rs2_busy), 32'h0);

    // Pre-load reg 5 and mark it busy, then reset mid-operation
    step();
    a_rd_we = 1; a_rd_addr = 5'd5; a_rd_data = 32'hDEADBEEF;
    a_issue_valid = 1; a_issue_rd = 5'd5;
    step();
    a_idle();
    @(negedge clk);
    chk("preload_data", a_rs1_data, 32'hDEADBEEF);
    chk("preload_busy", 32'(a_rs1_busy), 32'h1);
    step();
    a_rst = 1;
    step();
    a_rst = 0;
    @(negedge clk);
    chk("rst_clear_data", a_rs1_data, 32'h0);
    chk("rst_clear_busy", 32'(a_rs1_busy), 32'h0);

    // Write reg 7, then attempt writes/issue to x0
    step();
    a_rd_we = 1; a_rd_addr = 5'd7; a_rd_data = 32'h12345678;
    step();
    a_rd_we = 1; a_rd_addr = 5'd0; a_rd_data = 32'hFFFFFFFF;
    a_issue_valid = 1; a_issue_rd = 5'd0;
    step();
    a_idle();
    a_rs1_addr = 5'd7; a_rs2_addr = 5'd7;
    @(negedge clk);
    chk("r7_port1", a_rs1_data, 32'h12345678);
    chk("r7_port2", a_rs2_data, 32'h12345678);
    step();
    a_rs1_addr = 5'd0; a_rs2_addr = 5'd0;
    @(negedge clk);
    chk("x0_data", a_rs1_data, 32'h0);
    chk("x0_busy", 32'(a_rs2_busy), 32'h0);

    // Scoreboard lifecycle on reg 3
    step();
    a_issue_valid = 1; a_issue_rd = 5'd3;
    step();
    a_idle();
    a_rs2_addr = 5'd3;
    @(negedge clk);
    chk("r3_busy_set", 32'(a_rs2_busy), 32'h1);
    step();
    a_rd_we = 1; a_rd_addr = 5'd3; a_rd_data = 32'hA5;
    step();
    a_idle();
    @(negedge clk);
    chk("r3_busy_clr", 32'(a_rs2_busy), 32'h0);
    chk("r3_data", a_rs2_data, 32'hA5);

    // Simultaneous issue + writeback on reg 9: set wins, data still lands
    step();
    a_rd_we = 1; a_rd_addr = 5'd9; a_rd_data = 32'h99;
    a_issue_valid = 1; a_issue_rd = 5'd9;
    step();
    a_idle();
    a_rs1_addr = 5'd9;
    @(negedge clk);
    chk("r9_data", a_rs1_data, 32'h99);
    chk("r9_busy_kept", 32'(a_rs1_busy), 32'h1);
    step();
    a_rd_we = 1; a_rd_addr = 5'd9; a_rd_data = 32'h100;
    step();
    a_idle();
    @(negedge clk);
    chk("r9_data2", a_rs1_data, 32'h100);
    chk("r9_busy_clr", 32'(a_rs1_busy), 32'h0);

    // Same-cycle read of a register being written
    step();
    a_rd_we = 1; a_rd_addr = 5'd4; a_rd_data = 32'h44;
    a_issue_valid = 1; a_issue_rd = 5'd4;
    step();
    a_rd_we = 1; a_rd_addr = 5'd4; a_rd_data = 32'h55;
    a_issue_valid = 0;
    a_rs1_addr = 5'd4;
    @(negedge clk);
`ifdef REGFILE_BYPASS_EN
    chk("bypass_data", a_rs1_data, 32'h55);
    chk("bypass_busy", 32'(a_rs1_busy), 32'h0);
`else
    chk("nobypass_data", a_rs1_data, 32'h44);
    chk("nobypass_busy", 32'(a_rs1_busy), 32'h1);
`endif
    step();
    a_idle();
    @(negedge clk);
    chk("r4_after_write", a_rs1_data, 32'h55);

    // Random traffic on both instances, model-checked every cycle
    for (int n = 0; n < 1000; n++) begin
      step();
      a_rst         = ($urandom_range(0, 63) == 0);
      a_rd_we       = $urandom_range(0, 1) == 1;
      a_rd_addr     = 5'($urandom);
      a_rd_data     = $urandom;
      a_issue_valid = $urandom_range(0, 1) == 1;
      a_issue_rd    = 5'($urandom);
      a_rs1_addr    = ($urandom_range(0, 3) == 0) ? a_rd_addr : 5'($urandom);
      a_rs2_addr    = ($urandom_range(0, 3) == 0) ? a_issue_rd : 5'($urandom);
      b_rst         = ($urandom_range(0, 63) == 0);
      b_rd_we       = $urandom_range(0, 1) == 1;
      b_rd_addr     = 3'($urandom);
      b_rd_data     = 16'($urandom);
      b_issue_valid = $urandom_range(0, 1) == 1;
      b_issue_rd    = 3'($urandom);
      b_rs1_addr    = ($urandom_range(0, 3) == 0) ? b_rd_addr : 3'($urandom);
      b_rs2_addr    = 3'($urandom);
    end
    step();
    a_idle();
    b_rst = 0; b_rd_we = 0; b_issue_valid = 0;
    @(negedge clk);
    #1;
    check_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
